id_stage: RTL

//  Instruction-decode stage feeding the EX-stage ALU. Accepts 32-bit instruction words from fetch.

---
 rtl/id_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register-file read with write-through bypass, immediate
// extension, load-use stall detection, and a registered ID->EX bundle.
module id_stage #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [5:0]      op,
    output logic [XLEN-1:0] rs,
    output logic [XLEN-1:0] rt,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc4_out_2_ex,
    output logic [XLEN-1:0] i_data_2_ex,
    output logic [4:0]      dst,
    output logic            wb_en,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            illegal_op
);

    typedef enum logic [5:0] {
        OP_ADD = 6'd0,  OP_ADDI = 6'd1,  OP_SUB = 6'd2,  OP_SUBI = 6'd3,
        OP_MUL = 6'd4,  OP_MULI = 6'd5,  OP_OR  = 6'd6,  OP_ORI  = 6'd7,
        OP_AND = 6'd8,  OP_ANDI = 6'd9,  OP_XOR = 6'd10, OP_XORI = 6'd11,
        OP_LDW = 6'd12, OP_STW  = 6'd13, OP_BZ  = 6'd14, OP_BEQ  = 6'd15,
        OP_JR  = 6'd16
    } opcode_t;

    logic [5:0]      dec_op;
    logic [4:0]      rs_idx;
    logic [4:0]      rt_idx;
    logic [4:0]      rd_idx;
    logic            legal;
    logic [4:0]      dec_dst;
    logic            uses_rs;
    logic            uses_rt;
    logic            stall;
    logic            accept;
    logic            issue;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] regs [NREGS];

    assign dec_op  = if_instr[31:26];
    assign rs_idx  = if_instr[25:21];
    assign rt_idx  = if_instr[20:16];
    assign rd_idx  = if_instr[15:11];
    assign legal   = (dec_op <= OP_JR);
    assign imm_ext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_dst = '0;
        uses_rs = legal;
        uses_rt = 1'b0;
        case (opcode_t'(dec_op))
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                dec_dst = rd_idx;
                uses_rt = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI, OP_LDW:
                dec_dst = rt_idx;
            OP_STW, OP_BEQ:
                uses_rt = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        else if (wb_we && wb_addr == idx)
            return wb_data;
        else
            return regs[idx];
    endfunction

    assign rs_val = read_reg(rs_idx);
    assign rt_val = read_reg(rt_idx);

    // A load in EX cannot forward in time; hold the dependent instruction for one bubble.
    assign stall = ex_valid && mem_rd && (dst != 5'd0) &&
                   ((uses_rs && dst == rs_idx) || (uses_rt && dst == rt_idx));

    assign if_ready = !rst && !stall;
    assign accept   = if_valid && if_ready && !flush;
    assign issue    = accept && legal;

    // NOTE: the register file is deliberately reset because its cleared state is architectural;
    // sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            wb_en        <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            illegal_op   <= 1'b0;
            op           <= '0;
            rs           <= '0;
            rt           <= '0;
            imm          <= '0;
            pc4_out_2_ex <= '0;
            i_data_2_ex  <= '0;
            dst          <= '0;
        end else begin
            ex_valid   <= issue;
            wb_en      <= issue && (dec_dst != 5'd0);
            mem_rd     <= issue && (dec_op == OP_LDW);
            mem_wr     <= issue && (dec_op == OP_STW);
            illegal_op <= accept && !legal;
            // Data fields only move with a real issue; bubbles leave them untouched.
            if (issue) begin
                op           <= dec_op;
                rs           <= rs_val;
                rt           <= rt_val;
                imm          <= imm_ext;
                pc4_out_2_ex <= if_pc4;
                i_data_2_ex  <= {imm_ext[XLEN-3:0], 2'b00};
                dst          <= dec_dst;
            end
        end
    end

endmodule
